ex_stage: RTL and testbench

- Execute stage of the 5-stage 64-bit LEGv8 pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.
- Selects operand B, computes the ALU result, and maintains the NZCV flag register.
- Runs an iterative shift-add multiplier that stalls the upstream stages while it works.
- Owns the EX/MEM pipeline register and drives its outputs to the memory stage.

---
 rtl/ex_stage.sv | 189 ++++++++++++++++++
 tb/tb_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// LEGv8 execute stage: operand-B select, ALU, NZCV flags, iterative shift-add MUL, EX/MEM register.
// Define EX_MUL_EN to build the multiplier FSM; otherwise ALUOp 001 yields 0 in one cycle.
module ex_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             RegWrite,
  input  logic             MemWrite,
  input  logic             MemToReg,
  input  logic             flagWrite,
  input  logic [1:0]       ALUSrc,
  input  logic [2:0]       ALUOp,
  input  logic [4:0]       Rd,
  input  logic [WIDTH-1:0] Da,
  input  logic [WIDTH-1:0] Db,
  input  logic [WIDTH-1:0] Imm12Ext,
  input  logic [WIDTH-1:0] Daddr9Ext,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             RegWrite_mem,
  output logic             MemWrite_mem,
  output logic             MemToReg_mem,
  output logic [4:0]       Rd_mem,
  output logic [WIDTH-1:0] ALUResult_mem,
  output logic [WIDTH-1:0] StoreData_mem,
  output logic [3:0]       flags_out
);
  logic [WIDTH-1:0] op_b, b_eff, result;
  logic [WIDTH:0]   sum;
  logic             is_sub, is_mul, c_flag, v_flag;

  // Results of a finished MUL, presented to EX/MEM in the DONE cycle.
  logic             mul_done, done_rw, done_mw, done_mr;
  logic [4:0]       done_rd;
  logic [WIDTH-1:0] done_res, done_db;

  assign is_sub = (ALUOp == 3'b011);
  assign is_mul = (ALUOp == 3'b001);

  always_comb begin
    case (ALUSrc)
      2'b00:   op_b = Db;
      2'b01:   op_b = Imm12Ext;
      2'b10:   op_b = Daddr9Ext;
      default: op_b = '0;
    endcase
  end

  // One adder serves ADD and SUB; SUB is A + ~B + 1 so carry-out is the ARM no-borrow flag.
  assign b_eff = is_sub ? ~op_b : op_b;
  assign sum   = {1'b0, Da} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    result = op_b;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (ALUOp)
      3'b001: result = '0;
      3'b010, 3'b011: begin
        result = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (Da[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Da[WIDTH-1]);
      end
      3'b100: result = Da & op_b;
      3'b101: result = Da | op_b;
      3'b110: result = Da ^ op_b;
      default: result = op_b;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, mplier;
  logic [CW-1:0]    cnt;
  logic             mul_start;

  assign mul_start = (state == IDLE) && valid_in && is_mul && !flush_in;

  always_comb begin
    state_nx  = state;
    stall_out = 1'b0;
    mul_done  = 1'b0;
    if (flush_in) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (mul_start) begin
          stall_out = 1'b1;
          state_nx  = BUSY;
        end
        BUSY: begin
          stall_out = 1'b1;
          if (cnt == CW'(WIDTH-1)) state_nx = DONE;
        end
        DONE: begin
          mul_done = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operands and controls are latched at start so DONE does not depend on live ID/EX values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      done_res <= '0;
      done_db  <= '0;
      done_rd  <= '0;
      done_rw  <= 1'b0;
      done_mw  <= 1'b0;
      done_mr  <= 1'b0;
    end else begin
      state <= state_nx;
      if (mul_start) begin
        mcand    <= Da;
        mplier   <= op_b;
        done_res <= '0;
        cnt      <= '0;
        done_db  <= Db;
        done_rd  <= Rd;
        done_rw  <= RegWrite;
        done_mw  <= MemWrite;
        done_mr  <= MemToReg;
      end else if (state == BUSY) begin
        if (mplier[0]) done_res <= done_res + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end
`else
  assign stall_out = 1'b0;
  assign mul_done  = 1'b0;
  assign done_rw   = 1'b0;
  assign done_mw   = 1'b0;
  assign done_mr   = 1'b0;
  assign done_rd   = '0;
  assign done_res  = '0;
  assign done_db   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_mem  <= 1'b0;
      MemWrite_mem  <= 1'b0;
      MemToReg_mem  <= 1'b0;
      Rd_mem        <= '0;
      ALUResult_mem <= '0;
      StoreData_mem <= '0;
      flags_out     <= '0;
    end else begin
      if (flush_in || stall_out) begin
        RegWrite_mem  <= 1'b0;
        MemWrite_mem  <= 1'b0;
        MemToReg_mem  <= 1'b0;
        Rd_mem        <= Rd;
        ALUResult_mem <= result;
        StoreData_mem <= Db;
      end else if (mul_done) begin
        RegWrite_mem  <= done_rw;
        MemWrite_mem  <= done_mw;
        MemToReg_mem  <= done_mr;
        Rd_mem        <= done_rd;
        ALUResult_mem <= done_res;
        StoreData_mem <= done_db;
      end else begin
        RegWrite_mem  <= valid_in & RegWrite;
        MemWrite_mem  <= valid_in & MemWrite;
        MemToReg_mem  <= valid_in & MemToReg;
        Rd_mem        <= Rd;
        ALUResult_mem <= result;
        StoreData_mem <= Db;
      end
      if (valid_in && flagWrite && !flush_in && !stall_out && !is_mul && !mul_done)
        flags_out <= {result[WIDTH-1], (result == '0), c_flag, v_flag};
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, MUL/flush/back-to-back sequences, random ALU traffic vs a model.
module tb_ex_stage;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset, valid_in, RegWrite, MemWrite, MemToReg, flagWrite, flush_in;
  logic [1:0]    ALUSrc;
  logic [2:0]    ALUOp;
  logic [4:0]    Rd;
  logic [W-1:0]  Da, Db, Imm12Ext, Daddr9Ext;
  logic          stall_out, RegWrite_mem, MemWrite_mem, MemToReg_mem;
  logic [4:0]    Rd_mem;
  logic [W-1:0]  ALUResult_mem, StoreData_mem;
  logic [3:0]    flags_out;

  ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .flagWrite(flagWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Rd(Rd),
    .Da(Da), .Db(Db), .Imm12Ext(Imm12Ext), .Daddr9Ext(Daddr9Ext), .flush_in(flush_in),
    .stall_out(stall_out), .RegWrite_mem(RegWrite_mem), .MemWrite_mem(MemWrite_mem),
    .MemToReg_mem(MemToReg_mem), .Rd_mem(Rd_mem), .ALUResult_mem(ALUResult_mem),
    .StoreData_mem(StoreData_mem), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_flags;

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   src;
    logic [W-1:0] a, b, imm, dad;
    logic         fw;
    logic [W-1:0] er;
    logic [3:0]   ef;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, rw, mw, mr, fw, fl, input logic [1:0] src,
                       input logic [2:0] op, input logic [4:0] rd,
                       input logic [W-1:0] a, b, imm, dad);
    valid_in = v; RegWrite = rw; MemWrite = mw; MemToReg = mr; flagWrite = fw; flush_in = fl;
    ALUSrc = src; ALUOp = op; Rd = rd; Da = a; Db = b; Imm12Ext = imm; Daddr9Ext = dad;
  endtask

  task automatic idle;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd0, '0, '0, '0, '0);
  endtask

  function automatic logic [W-1:0] sel_b(input logic [1:0] s, input logic [W-1:0] b, imm, dad);
    case (s)
      2'b00:   return b;
      2'b01:   return imm;
      2'b10:   return dad;
      default: return '0;
    endcase
  endfunction

  // Reference ALU from arithmetic definitions: carry as unsigned overflow / no-borrow,
  // V as "true signed result does not fit in W bits".
  function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] r, output logic c, v);
    logic [W:0]        u;
    logic signed [W:0] s;
    c = 1'b0; v = 1'b0;
    case (op)
      3'b001: r = '0;
      3'b010: begin
        u = {1'b0, a} + {1'b0, b};
        r = a + b;
        c = u[W];
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        v = (s != $signed({r[W-1], r}));
      end
      3'b011: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        v = (s != $signed({r[W-1], r}));
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = b;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return W'($urandom_range(0, 15));
      2:       return 64'h8000_0000_0000_0000 - W'($urandom_range(0, 2));
      default: return ~W'($urandom_range(0, 3));
    endcase
  endfunction

`ifdef EX_MUL_EN
  task automatic wait_mul(output int n, output int bad);
    n = 0; bad = 0;
    while (stall_out && n < 200) begin
      n++;
      tick;
      if (RegWrite_mem || MemWrite_mem || MemToReg_mem) bad++;
    end
  endtask
`endif

  initial begin
    tbl[0]  = '{3'b011, 2'b00, 64'd5, 64'd5, 64'd0, 64'd0, 1'b1, 64'd0, 4'b0110};
    tbl[1]  = '{3'b010, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd9, 64'd1, 64'd0, 1'b1,
                64'h8000_0000_0000_0000, 4'b1001};
    tbl[2]  = '{3'b010, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b1, 64'd0, 4'b0110};
    tbl[3]  = '{3'b011, 2'b00, 64'd3, 64'd5, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    tbl[4]  = '{3'b011, 2'b01, 64'h8000_0000_0000_0000, 64'd0, 64'd1, 64'd0, 1'b1,
                64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    tbl[5]  = '{3'b100, 2'b00, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0, 1'b1, 64'h00F0, 4'b0000};
    tbl[6]  = '{3'b101, 2'b10, 64'h1, 64'hDEAD, 64'd0, 64'h100, 1'b1, 64'h101, 4'b0000};
    tbl[7]  = '{3'b110, 2'b00, 64'h5555, 64'h5555, 64'd0, 64'd0, 1'b1, 64'd0, 4'b0100};
    tbl[8]  = '{3'b000, 2'b01, 64'h7, 64'h3, 64'h8000_0000_0000_0000, 64'd0, 1'b1,
                64'h8000_0000_0000_0000, 4'b1000};
    tbl[9]  = '{3'b111, 2'b11, 64'h7, 64'h3, 64'h5, 64'h6, 1'b1, 64'd0, 4'b0100};
    tbl[10] = '{3'b010, 2'b00, 64'd2, 64'd3, 64'd0, 64'd0, 1'b0, 64'd5, 4'b0100};

    reset = 1'b1;
    idle;
    tick; tick;
    chk("rst stall", W'(stall_out), 0);
    chk("rst regwrite", W'(RegWrite_mem), 0);
    chk("rst memwrite", W'(MemWrite_mem), 0);
    chk("rst memtoreg", W'(MemToReg_mem), 0);
    chk("rst rd", W'(Rd_mem), 0);
    chk("rst result", ALUResult_mem, 0);
    chk("rst storedata", StoreData_mem, 0);
    chk("rst flags", W'(flags_out), 0);
    reset = 1'b0;
    exp_flags = 4'b0000;

    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, 0, tbl[i].fw, 0, tbl[i].src, tbl[i].op, 5'(i + 1),
            tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].dad);
      #1;
      chk($sformatf("tbl%0d stall", i), W'(stall_out), 0);
      tick;
      chk($sformatf("tbl%0d result", i), ALUResult_mem, tbl[i].er);
      chk($sformatf("tbl%0d flags", i), W'(flags_out), W'(tbl[i].ef));
      chk($sformatf("tbl%0d regwrite", i), W'(RegWrite_mem), 1);
      chk($sformatf("tbl%0d rd", i), W'(Rd_mem), W'(i + 1));
      chk($sformatf("tbl%0d storedata", i), StoreData_mem, tbl[i].b);
    end
    exp_flags = 4'b0100;

`ifdef EX_MUL_EN
    begin
      int n, bad;
      // Long MUL: WIDTH+1 stall cycles of bubbles, then the product with flags untouched.
      drive(1, 1, 0, 0, 1, 0, 2'b00, 3'b001, 5'd7, 64'h1234, 64'h10, '0, '0);
      #1;
      wait_mul(n, bad);
      chk("mul stall cycles", W'(n), W'(W + 1));
      chk("mul bubbles", W'(bad), 0);
      tick;
      idle;
      chk("mul result", ALUResult_mem, 64'h12340);
      chk("mul regwrite", W'(RegWrite_mem), 1);
      chk("mul rd", W'(Rd_mem), 7);
      chk("mul flags", W'(flags_out), W'(exp_flags));

      // Flush on BUSY iteration 10.
      drive(1, 1, 0, 0, 1, 0, 2'b00, 3'b001, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, '0, '0);
      tick;
      for (int k = 0; k < 10; k++) tick;
      chk("flush pre stall", W'(stall_out), 1);
      flush_in = 1'b1;
      #1;
      chk("flush stall drop", W'(stall_out), 0);
      tick;
      chk("flush bubble", W'(RegWrite_mem), 0);
      chk("flush flags", W'(flags_out), W'(exp_flags));
      drive(1, 1, 0, 0, 0, 0, 2'b00, 3'b010, 5'd4, 64'd1, 64'd1, '0, '0);
      #1;
      chk("post flush idle", W'(stall_out), 0);
      tick;
      chk("post flush add", ALUResult_mem, 2);
      chk("post flush rw", W'(RegWrite_mem), 1);

      // MUL immediately followed by ADD.
      drive(1, 1, 0, 0, 0, 0, 2'b00, 3'b001, 5'd1, 64'd2, 64'd3, '0, '0);
      #1;
      wait_mul(n, bad);
      chk("b2b stall cycles", W'(n), W'(W + 1));
      tick;
      chk("b2b mul result", ALUResult_mem, 6);
      chk("b2b mul rd", W'(Rd_mem), 1);
      chk("b2b mul rw", W'(RegWrite_mem), 1);
      drive(1, 1, 0, 0, 0, 0, 2'b00, 3'b010, 5'd2, 64'd1, 64'd1, '0, '0);
      #1;
      chk("b2b add stall", W'(stall_out), 0);
      tick;
      chk("b2b add result", ALUResult_mem, 2);
      chk("b2b add rd", W'(Rd_mem), 2);
      idle;
      tick;
      chk("b2b no dup", W'(RegWrite_mem), 0);
    end
`else
    // Without the multiplier, MUL is a single-cycle op yielding 0 and never writes flags.
    drive(1, 1, 0, 0, 1, 0, 2'b00, 3'b001, 5'd3, 64'd5, 64'd6, '0, '0);
    #1;
    chk("nomul stall", W'(stall_out), 0);
    tick;
    chk("nomul result", ALUResult_mem, 0);
    chk("nomul regwrite", W'(RegWrite_mem), 1);
    chk("nomul flags", W'(flags_out), W'(exp_flags));
`endif

    for (int i = 0; i < 300; i++) begin
      logic         v, rw, mw, mr, fw, fl, c, ov;
      logic [1:0]   src;
      logic [2:0]   op;
      logic [4:0]   rd;
      logic [W-1:0] a, b, imm, dad, r;
      v = 1'($urandom_range(0, 3) != 0);
      rw = 1'($urandom); mw = 1'($urandom); mr = 1'($urandom); fw = 1'($urandom);
      fl = 1'($urandom_range(0, 7) == 0);
      src = 2'($urandom); op = 3'($urandom); rd = 5'($urandom);
`ifdef EX_MUL_EN
      if (op == 3'b001) op = 3'b010;
`endif
      a = rnd_val(); b = rnd_val(); imm = rnd_val(); dad = rnd_val();
      drive(v, rw, mw, mr, fw, fl, src, op, rd, a, b, imm, dad);
      tick;
      ref_alu(op, a, sel_b(src, b, imm, dad), r, c, ov);
      if (v && fw && !fl && op != 3'b001) exp_flags = {r[W-1], (r == '0), c, ov};
      chk($sformatf("rnd%0d flags", i), W'(flags_out), W'(exp_flags));
      chk($sformatf("rnd%0d regwrite", i), W'(RegWrite_mem), W'(v & rw & ~fl));
      chk($sformatf("rnd%0d memwrite", i), W'(MemWrite_mem), W'(v & mw & ~fl));
      chk($sformatf("rnd%0d memtoreg", i), W'(MemToReg_mem), W'(v & mr & ~fl));
      if (v && !fl) begin
        chk($sformatf("rnd%0d result op%0d", i, op), ALUResult_mem, r);
        chk($sformatf("rnd%0d rd", i), W'(Rd_mem), W'(rd));
        chk($sformatf("rnd%0d storedata", i), StoreData_mem, b);
      end
    end

`ifdef EX_MUL_EN
    // Reset while the multiplier is busy.
    drive(1, 1, 1, 1, 1, 0, 2'b00, 3'b001, 5'd5, 64'd9, 64'd9, '0, '0);
    tick; tick; tick;
    reset = 1'b1;
    tick;
    idle;
    #1;
    chk("midrst stall", W'(stall_out), 0);
    chk("midrst regwrite", W'(RegWrite_mem), 0);
    chk("midrst result", ALUResult_mem, 0);
    chk("midrst flags", W'(flags_out), 0);
    reset = 1'b0;
    tick;
    chk("midrst idle", W'(stall_out), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
